im_filter_frame_ctrl: RTL and testbench

//  Frame-aware control unit for the spatial-filter pipeline; successor to the single-mode no-border controller.

---
 rtl/im_filter_pkg.sv | 42 ++++
 rtl/im_raster_counter.sv | 47 ++++
 rtl/im_filter_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_im_filter_frame_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_filter_pkg.sv
// Shared definitions for the spatial-filter frame controller.
// Contents:
//   data_id_t  - tag carried with every input word (pixel, coefficient, config, frame start)
//   border_t   - border handling mode applied to windows near the image edge
//   state_t    - frame controller state encoding
//   SEL_W      - width of the sel_* outputs for the default 7x7 mask
//   sel_width  - the same width for an arbitrary odd mask size
package im_filter_pkg;

  typedef enum logic [1:0] {
    ID_PIX    = 2'b00,
    ID_COEF   = 2'b01,
    ID_CFG    = 2'b10,
    ID_FSTART = 2'b11
  } data_id_t;

  typedef enum logic [1:0] {
    BM_NONE   = 2'd0,
    BM_ZERO   = 2'd1,
    BM_MIRROR = 2'd2,
    BM_REPL   = 2'd3
  } border_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int MASK_WIDTH_DEF = 7;
  localparam int H_DEF          = MASK_WIDTH_DEF / 2;
  localparam int SEL_W          = $clog2(H_DEF + 1);

  // Bits needed to encode 0..H missing rows/columns; never narrower than 1.
  function automatic int sel_width(input int mask_width);
    int w;
    w = $clog2(mask_width / 2 + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/im_raster_counter.sv
// Raster-order row/column counter.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear to (0,0); wins over en
//   en        - advance one position in raster order
//   row, col  - current position
//   wrap      - current position is the last one of the frame (next en returns to 0,0)
module im_raster_counter #(
  parameter int CNT_BIT   = 10,
  parameter int ROW_WIDTH = 640,
  parameter int COL_WIDTH = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [CNT_BIT-1:0] row,
  output logic [CNT_BIT-1:0] col,
  output logic               wrap
);

  localparam logic [CNT_BIT-1:0] COL_MAX = CNT_BIT'(ROW_WIDTH - 1);
  localparam logic [CNT_BIT-1:0] ROW_MAX = CNT_BIT'(COL_WIDTH - 1);

  logic col_end;

  assign col_end = (col == COL_MAX);
  assign wrap    = col_end && (row == ROW_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= wrap ? '0 : row + CNT_BIT'(1);
      end else begin
        col <= col + CNT_BIT'(1);
      end
    end
  end

endmodule

// File: rtl/im_filter_frame_ctrl.sv
// Frame-aware control unit for the spatial-filter pipeline.
// Decodes the tagged input stream and drives the row buffers, the coefficient
// file and the filter-function enable, with selectable border handling.
// Ports:
//   clk, reset_in         - clock, asynchronous active-high reset
//   data_in_valid/ready   - input handshake; a word is taken on valid & ready
//   data_in, data_id      - payload and its tag (pixel/coef/config/frame start)
//   buf_valid, buf_pix    - push into the row buffers (pixel, or 0 while flushing)
//   cf_wr_en, cf_wr_data  - coefficient-file write
//   sel_*                 - rows/cols of the window lying outside the image
//   border_mode           - mode the current/next frame runs in
//   en_funct              - window centred at (cr,cc) is ready for the filter
//   frame_done            - one-cycle pulse after the last en_funct of a frame
//   busy, err             - not idle; sticky protocol error (cleared by frame start)
module im_filter_frame_ctrl
  import im_filter_pkg::*;
#(
  parameter int DATA_BIT   = 15,
  parameter int ROW_WIDTH  = 640,
  parameter int COL_WIDTH  = 480,
  parameter int MASK_WIDTH = 7,
  parameter int CNT_BIT    = 10,
  parameter int COFCNT_BIT = 15,
  parameter int PIX_BIT    = 8,
  localparam int SEL_BITS  = sel_width(MASK_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  input  logic [DATA_BIT-1:0]   data_in,
  input  logic [1:0]            data_id,
  output logic                  buf_valid,
  output logic [PIX_BIT-1:0]    buf_pix,
  output logic                  cf_wr_en,
  output logic [COFCNT_BIT-1:0] cf_wr_data,
  output logic [SEL_BITS-1:0]   sel_top_row,
  output logic [SEL_BITS-1:0]   sel_btm_row,
  output logic [SEL_BITS-1:0]   sel_left_col,
  output logic [SEL_BITS-1:0]   sel_right_col,
  output logic [1:0]            border_mode,
  output logic                  en_funct,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  err
);

  localparam int H      = MASK_WIDTH / 2;
  localparam int NCOEF  = MASK_WIDTH * MASK_WIDTH;
  localparam int CIDX_W = (NCOEF > 1) ? $clog2(NCOEF) : 1;

  localparam logic [CNT_BIT-1:0] H_C   = CNT_BIT'(H);
  localparam logic [CNT_BIT-1:0] CR_HI = CNT_BIT'(COL_WIDTH - 1 - H);
  localparam logic [CNT_BIT-1:0] CC_HI = CNT_BIT'(ROW_WIDTH - 1 - H);
  localparam logic [CIDX_W-1:0]  CIDX_MAX = CIDX_W'(NCOEF - 1);

  // Rows/cols missing on the low side of a window centred at v.
  function automatic logic [SEL_BITS-1:0] miss_lo(input logic [CNT_BIT-1:0] v);
    if (v < H_C) return SEL_BITS'(H_C - v);
    return '0;
  endfunction

  // Rows/cols missing on the high side, where lim is the last fully-inside centre.
  function automatic logic [SEL_BITS-1:0] miss_hi(input logic [CNT_BIT-1:0] v,
                                                  input logic [CNT_BIT-1:0] lim);
    if (v > lim) return SEL_BITS'(v - lim);
    return '0;
  endfunction

  state_t state, state_nx;

  logic               accept;
  logic [CNT_BIT-1:0] ar, ac, cr, cc;
  logic               arr_last, cen_last;
  logic               arr_en, arr_clr, cen_en, cen_clr;
  logic               centre_on, centre_on_nx;
  logic               at_d, adv, push, inner;
  logic [CIDX_W-1:0]  coef_idx, coef_idx_nx;

  logic                  buf_valid_nx;
  logic [PIX_BIT-1:0]    buf_pix_nx;
  logic                  cf_wr_en_nx;
  logic [COFCNT_BIT-1:0] cf_wr_data_nx;
  logic [SEL_BITS-1:0]   sel_top_nx, sel_btm_nx, sel_left_nx, sel_right_nx;
  logic [1:0]            mode_nx;
  logic                  en_funct_nx, frame_done_nx, err_nx;

  assign accept = data_in_valid && data_in_ready;

  // Arrival position: where the next pushed pixel lands in the raster.
  im_raster_counter #(
    .CNT_BIT   (CNT_BIT),
    .ROW_WIDTH (ROW_WIDTH),
    .COL_WIDTH (COL_WIDTH)
  ) u_arrival (
    .clk  (clk),
    .rst  (reset_in),
    .clr  (arr_clr),
    .en   (arr_en),
    .row  (ar),
    .col  (ac),
    .wrap (arr_last)
  );

  // Centre position: the window centre that becomes complete on the next advance.
  im_raster_counter #(
    .CNT_BIT   (CNT_BIT),
    .ROW_WIDTH (ROW_WIDTH),
    .COL_WIDTH (COL_WIDTH)
  ) u_centre (
    .clk  (clk),
    .rst  (reset_in),
    .clr  (cen_clr),
    .en   (cen_en),
    .row  (cr),
    .col  (cc),
    .wrap (cen_last)
  );

  // The centre starts moving once H rows plus H pixels are buffered, i.e. when
  // the push at arrival index H*ROW_WIDTH+H happens.
  assign at_d  = (ar == H_C) && (ac == H_C);
  assign inner = (cr >= H_C) && (cr <= CR_HI) && (cc >= H_C) && (cc <= CC_HI);

  always_comb begin
    state_nx      = state;
    arr_en        = 1'b0;
    arr_clr       = 1'b0;
    cen_clr       = 1'b0;
    centre_on_nx  = centre_on;
    push          = 1'b0;
    buf_pix_nx    = '0;
    cf_wr_en_nx   = 1'b0;
    cf_wr_data_nx = cf_wr_data;
    coef_idx_nx   = coef_idx;
    mode_nx       = border_mode;
    err_nx        = err;
    frame_done_nx = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (data_id)
            ID_COEF: begin
              cf_wr_en_nx   = 1'b1;
              cf_wr_data_nx = data_in[COFCNT_BIT-1:0];
              coef_idx_nx   = (coef_idx == CIDX_MAX) ? '0 : coef_idx + CIDX_W'(1);
            end
            ID_CFG:  mode_nx = data_in[1:0];
            ID_PIX:  err_nx  = 1'b1;
            default: begin
              arr_clr      = 1'b1;
              cen_clr      = 1'b1;
              centre_on_nx = 1'b0;
              err_nx       = 1'b0;
              state_nx     = ST_STREAM;
            end
          endcase
        end
      end
      ST_STREAM: begin
        if (accept) begin
          case (data_id)
            ID_PIX: begin
              push       = 1'b1;
              buf_pix_nx = data_in[PIX_BIT-1:0];
              arr_en     = 1'b1;
              if (arr_last)
                state_nx = (border_mode == BM_NONE) ? ST_DONE : ST_FLUSH;
            end
            ID_FSTART: begin
              // Abort: restart the frame in place, the old one never completes.
              arr_clr      = 1'b1;
              cen_clr      = 1'b1;
              centre_on_nx = 1'b0;
              err_nx       = 1'b0;
            end
            default: err_nx = 1'b1;
          endcase
        end
      end
      ST_FLUSH: begin
        // Zero pushes drain the last H rows + H pixels worth of centres.
        push = 1'b1;
        if (cen_last) state_nx = ST_DONE;
      end
      default: begin
        frame_done_nx = 1'b1;
        state_nx      = ST_IDLE;
      end
    endcase

    adv = push && (centre_on || at_d);
    if (adv) centre_on_nx = 1'b1;
    if (arr_clr) centre_on_nx = 1'b0;
    cen_en       = adv;
    buf_valid_nx = push;

    en_funct_nx  = 1'b0;
    sel_top_nx   = '0;
    sel_btm_nx   = '0;
    sel_left_nx  = '0;
    sel_right_nx = '0;
    if (adv) begin
      if (border_mode == BM_NONE) begin
        en_funct_nx = inner;
      end else begin
        en_funct_nx  = 1'b1;
        sel_top_nx   = miss_lo(cr);
        sel_btm_nx   = miss_hi(cr, CR_HI);
        sel_left_nx  = miss_lo(cc);
        sel_right_nx = miss_hi(cc, CC_HI);
      end
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Output stage: every output is the registered image of the accepted word.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      centre_on     <= 1'b0;
      coef_idx      <= '0;
      data_in_ready <= 1'b0;
      buf_valid     <= 1'b0;
      buf_pix       <= '0;
      cf_wr_en      <= 1'b0;
      cf_wr_data    <= '0;
      sel_top_row   <= '0;
      sel_btm_row   <= '0;
      sel_left_col  <= '0;
      sel_right_col <= '0;
      border_mode   <= '0;
      en_funct      <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      centre_on     <= centre_on_nx;
      coef_idx      <= coef_idx_nx;
      data_in_ready <= (state_nx == ST_IDLE) || (state_nx == ST_STREAM);
      buf_valid     <= buf_valid_nx;
      buf_pix       <= buf_pix_nx;
      cf_wr_en      <= cf_wr_en_nx;
      cf_wr_data    <= cf_wr_data_nx;
      sel_top_row   <= sel_top_nx;
      sel_btm_row   <= sel_btm_nx;
      sel_left_col  <= sel_left_nx;
      sel_right_col <= sel_right_nx;
      border_mode   <= mode_nx;
      en_funct      <= en_funct_nx;
      frame_done    <= frame_done_nx;
      busy          <= (state_nx != ST_IDLE);
      err           <= err_nx;
    end
  end

endmodule

// File: tb/tb_im_filter_frame_ctrl.sv
// Directed bench for im_filter_frame_ctrl on an 8x6 image with a 3x3 mask.
// Expected pushes, windows and coefficient writes are queued as words are
// driven and checked as the DUT emits them.
module tb_im_filter_frame_ctrl;

  localparam int RW  = 8;
  localparam int CW  = 6;
  localparam int MW  = 3;
  localparam int H   = MW / 2;
  localparam int D   = H * RW + H;
  localparam int TOT = RW * CW;
  localparam int SW  = 1;
  localparam int DB  = 15;
  localparam int CB  = 4;
  localparam int CFB = 15;
  localparam int PB  = 8;

  logic           clk = 1'b0;
  logic           reset_in;
  logic           data_in_valid;
  logic           data_in_ready;
  logic [DB-1:0]  data_in;
  logic [1:0]     data_id;
  logic           buf_valid;
  logic [PB-1:0]  buf_pix;
  logic           cf_wr_en;
  logic [CFB-1:0] cf_wr_data;
  logic [SW-1:0]  sel_top_row, sel_btm_row, sel_left_col, sel_right_col;
  logic [1:0]     border_mode;
  logic           en_funct, frame_done, busy, err;
  logic [35:0]    all_out;

  typedef struct packed {
    logic [SW-1:0] top;
    logic [SW-1:0] btm;
    logic [SW-1:0] left;
    logic [SW-1:0] right;
    logic [PB-1:0] pix;
  } fn_t;

  fn_t            q_fn[$];
  logic [PB-1:0]  q_buf[$];
  logic [CFB-1:0] q_cf[$];

  int errors = 0;
  int checks = 0;
  int fn_cnt = 0, done_cnt = 0, cf_cnt = 0, rdy_lo = 0, cyc = 0, last_fn_cyc = -10;

  assign all_out = {data_in_ready, buf_valid, buf_pix, cf_wr_en, cf_wr_data,
                    sel_top_row, sel_btm_row, sel_left_col, sel_right_col,
                    border_mode, en_funct, frame_done, busy, err};

  im_filter_frame_ctrl #(
    .DATA_BIT   (DB),
    .ROW_WIDTH  (RW),
    .COL_WIDTH  (CW),
    .MASK_WIDTH (MW),
    .CNT_BIT    (CB),
    .COFCNT_BIT (CFB),
    .PIX_BIT    (PB)
  ) dut (
    .clk           (clk),
    .reset_in      (reset_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_in       (data_in),
    .data_id       (data_id),
    .buf_valid     (buf_valid),
    .buf_pix       (buf_pix),
    .cf_wr_en      (cf_wr_en),
    .cf_wr_data    (cf_wr_data),
    .sel_top_row   (sel_top_row),
    .sel_btm_row   (sel_btm_row),
    .sel_left_col  (sel_left_col),
    .sel_right_col (sel_right_col),
    .border_mode   (border_mode),
    .en_funct      (en_funct),
    .frame_done    (frame_done),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor / scoreboard consumer.
  initial begin
    fn_t            r;
    logic [PB-1:0]  p;
    logic [CFB-1:0] c;
    forever begin
      @(negedge clk);
      if (!reset_in) begin
        cyc++;
        if (!data_in_ready) rdy_lo++;
        if (buf_valid) begin
          checks++;
          assert (q_buf.size() != 0) else begin
            errors++;
            $error("FAIL buf_extra: observed push of %0d expected no push", buf_pix);
          end
          if (q_buf.size() != 0) begin
            p = q_buf.pop_front();
            chk("buf_pix", buf_pix, p);
          end
        end
        if (en_funct) begin
          fn_cnt++;
          last_fn_cyc = cyc;
          checks++;
          assert (q_fn.size() != 0) else begin
            errors++;
            $error("FAIL fn_extra: observed en_funct at pix %0d expected none", buf_pix);
          end
          if (q_fn.size() != 0) begin
            r = q_fn.pop_front();
            chk("fn_sel_pix", {sel_top_row, sel_btm_row, sel_left_col, sel_right_col, buf_pix}, r);
          end
        end
        if (cf_wr_en) begin
          cf_cnt++;
          checks++;
          assert (q_cf.size() != 0) else begin
            errors++;
            $error("FAIL cf_extra: observed write of %0d expected none", cf_wr_data);
          end
          if (q_cf.size() != 0) begin
            c = q_cf.pop_front();
            chk("cf_wr_data", cf_wr_data, c);
          end
        end
        if (frame_done) begin
          done_cnt++;
          chk("done_after_fn", cyc, last_fn_cyc + 1);
        end
      end
    end
  end

  // Drive one word; it is taken at the first rising edge with ready high.
  task automatic send(input logic [1:0] id, input int d);
    int n = 0;
    @(negedge clk);
    data_in_valid = 1'b1;
    data_id       = id;
    data_in       = DB'(d);
    while (!data_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", data_in_ready, 1);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
  endtask

  // Expected outcome of the k-th buffer push of a frame.
  task automatic expect_push(input int k, input int mode, input logic [PB-1:0] pix);
    int  c, cr, cc;
    fn_t r;
    q_buf.push_back(pix);
    if (k >= D) begin
      c  = k - D;
      cr = c / RW;
      cc = c % RW;
      r.pix = pix;
      if (mode == 0) begin
        r.top = '0; r.btm = '0; r.left = '0; r.right = '0;
        if (cr >= H && cr <= CW - 1 - H && cc >= H && cc <= RW - 1 - H) q_fn.push_back(r);
      end else begin
        r.top   = SW'((cr < H) ? H - cr : 0);
        r.btm   = SW'((cr > CW - 1 - H) ? cr - (CW - 1 - H) : 0);
        r.left  = SW'((cc < H) ? H - cc : 0);
        r.right = SW'((cc > RW - 1 - H) ? cc - (RW - 1 - H) : 0);
        q_fn.push_back(r);
      end
    end
  endtask

  task automatic send_frame(input int mode, input int npix, input int base);
    logic [PB-1:0] p;
    send(2'b11, 0);
    for (int k = 0; k < npix; k++) begin
      p = PB'(base + k);
      expect_push(k, mode, p);
      send(2'b00, int'(p));
    end
    if (npix == TOT && mode != 0)
      for (int k = TOT; k < TOT + D; k++) expect_push(k, mode, '0);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, d0, c0, r0;
    reset_in      = 1'b1;
    data_in_valid = 1'b0;
    data_in       = '0;
    data_id       = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out, 0);
    #1 reset_in = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", data_in_ready, 1);
    chk("busy_idle", busy, 0);

    // Reset in the middle of a replicate-mode frame.
    send(2'b10, 3);
    chk("mode_cfg3", border_mode, 3);
    d0 = done_cnt;
    send_frame(3, 20, 1);
    #2 reset_in = 1'b1;
    #1 chk("reset_mid_outputs", all_out, 0);
    q_buf.delete();
    q_fn.delete();
    @(negedge clk);
    chk("busy_after_reset", busy, 0);
    chk("no_done_on_reset", done_cnt - d0, 0);
    #1 reset_in = 1'b0;
    send(2'b10, 3);
    f0 = fn_cnt; d0 = done_cnt;
    send_frame(3, TOT, 50);
    wait_idle();
    chk("fn_after_reset", fn_cnt - f0, TOT);
    chk("done_after_reset", done_cnt - d0, 1);
    chk("fnq_empty1", q_fn.size(), 0);
    chk("bufq_empty1", q_buf.size(), 0);

    // Coefficient load, including one past the full mask.
    c0 = cf_cnt;
    for (int i = 1; i <= MW * MW + 1; i++) begin
      q_cf.push_back(CFB'(i * 37));
      send(2'b01, i * 37);
    end
    repeat (2) @(negedge clk);
    chk("cf_count", cf_cnt - c0, MW * MW + 1);
    chk("cfq_empty", q_cf.size(), 0);

    // Pixel outside a frame is dropped and flagged.
    send(2'b00, 77);
    chk("err_idle_pix", err, 1);

    // No-border frame.
    send(2'b10, 0);
    chk("mode_cfg0", border_mode, 0);
    f0 = fn_cnt; d0 = done_cnt; r0 = rdy_lo;
    send_frame(0, TOT, 100);
    chk("err_cleared_fstart", err, 0);
    wait_idle();
    chk("fn_mode0", fn_cnt - f0, (RW - 2 * H) * (CW - 2 * H));
    chk("done_mode0", done_cnt - d0, 1);
    chk("rdy_lo_mode0", rdy_lo - r0, 1);
    chk("fnq_empty3", q_fn.size(), 0);
    chk("bufq_empty3", q_buf.size(), 0);

    // Coefficient and config words inside a frame are dropped.
    send(2'b10, 2);
    send(2'b11, 0);
    c0 = cf_cnt;
    send(2'b01, 5);
    chk("err_stream_coef", err, 1);
    send(2'b10, 1);
    chk("mode_locked", border_mode, 2);
    @(negedge clk);
    chk("no_cf_in_stream", cf_cnt - c0, 0);

    // Mirror frame with flush (frame start also clears err).
    f0 = fn_cnt; d0 = done_cnt; r0 = rdy_lo;
    send_frame(2, TOT, 150);
    wait_idle();
    chk("err_after_mode2", err, 0);
    chk("fn_mode2", fn_cnt - f0, TOT);
    chk("done_mode2", done_cnt - d0, 1);
    chk("rdy_lo_flush", rdy_lo - r0, D + 1);
    chk("fnq_empty4", q_fn.size(), 0);
    chk("bufq_empty4", q_buf.size(), 0);

    // Frame abort at pixel 30, then a full frame.
    send(2'b10, 1);
    f0 = fn_cnt; d0 = done_cnt;
    send_frame(1, 30, 10);
    send_frame(1, TOT, 60);
    wait_idle();
    chk("fn_abort", fn_cnt - f0, (30 - D) + TOT);
    chk("done_abort", done_cnt - d0, 1);
    chk("fnq_empty5", q_fn.size(), 0);
    chk("bufq_empty5", q_buf.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
